// File: rtl/me_pkg.sv
// ---------------------------------------------------------------------------
// me_pkg
// Shared constants and types for the ME search-window row loader.
//   PIX_WIDTH       : bits per pixel
//   IN_WIDTH        : memory beat width (8 pixels)
//   OUTPUT_WIDTH    : row head width (pixels 0..15)
//   STAGE_OUT_WIDTH : row tail width (pixels 16..22)
//   BEATS_PER_ROW   : beats assembled into one row
//   PIX_PER_ROW     : pixels kept per row (pixel 23 of the last beat is dropped)
//   wr_state_e      : write FSM state; the encoding doubles as the beat index
// ---------------------------------------------------------------------------
package me_pkg;

    localparam int PIX_WIDTH       = 8;
    localparam int BEAT_PIX        = 8;
    localparam int HEAD_PIX        = 16;
    localparam int BEATS_PER_ROW   = 3;
    localparam int PIX_PER_ROW     = 23;

    localparam int IN_WIDTH        = BEAT_PIX * PIX_WIDTH;
    localparam int OUTPUT_WIDTH    = HEAD_PIX * PIX_WIDTH;
    localparam int STAGE_OUT_WIDTH = (PIX_PER_ROW - HEAD_PIX) * PIX_WIDTH;
    localparam int ROW_STORE_WIDTH = PIX_PER_ROW * PIX_WIDTH;
    localparam int ERR_CNT_WIDTH   = 8;

    typedef enum logic [1:0] {
        W_B0 = 2'd0,
        W_B1 = 2'd1,
        W_B2 = 2'd2
    } wr_state_e;

endpackage

// File: rtl/ref_row_loader_if.sv
// ---------------------------------------------------------------------------
// ref_row_loader_if
// Beat input and row output handshakes of ref_row_loader.
//   in_data_i   : pixel beat, pixel k at [8k+7:8k]
//   in_valid_i  : beat valid
//   in_sof_i    : beat is the first beat of a row
//   in_ready_o  : loader can accept a beat
//   data_out0   : row pixels 0..15, pixel 0 at [7:0]
//   data_out1   : row pixels 16..22, pixel 16 at [7:0]
//   out_valid_o : complete row presented
//   out_ready_i : consumer takes the row
// Modports: master = producer/consumer side, slave = loader side.
// ---------------------------------------------------------------------------
interface ref_row_loader_if;
    import me_pkg::*;

    logic [IN_WIDTH-1:0]        in_data_i;
    logic                       in_valid_i;
    logic                       in_sof_i;
    logic                       in_ready_o;
    logic [OUTPUT_WIDTH-1:0]    data_out0;
    logic [STAGE_OUT_WIDTH-1:0] data_out1;
    logic                       out_valid_o;
    logic                       out_ready_i;

    modport master (
        output in_data_i, in_valid_i, in_sof_i, out_ready_i,
        input  in_ready_o, data_out0, data_out1, out_valid_o
    );

    modport slave (
        input  in_data_i, in_valid_i, in_sof_i, out_ready_i,
        output in_ready_o, data_out0, data_out1, out_valid_o
    );

endinterface

// File: rtl/row_pingpong_buf.sv
// ---------------------------------------------------------------------------
// row_pingpong_buf
// Two-row ping-pong buffer: beats are written into the bank under the write
// pointer, the bank under the read pointer drives the outputs.
//   clk_i, rst_i : clock, synchronous active-high reset
//   i_wr_en      : write beat i_wr_data at beat slot i_wr_beat
//   i_wr_beat    : beat slot 0..2
//   i_wr_data    : beat data
//   i_wr_last    : this write completes the row (mark bank full, advance)
//   i_rd_pop     : consumer takes the presented row
//   o_wr_ok      : fewer than two rows held
//   o_rd_valid   : at least one row held
//   o_head       : pixels 0..15 of the read bank
//   o_tail       : pixels 16..22 of the read bank
// ---------------------------------------------------------------------------
module row_pingpong_buf
    import me_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       i_wr_en,
    input  logic [1:0]                 i_wr_beat,
    input  logic [IN_WIDTH-1:0]        i_wr_data,
    input  logic                       i_wr_last,
    input  logic                       i_rd_pop,
    output logic                       o_wr_ok,
    output logic                       o_rd_valid,
    output logic [OUTPUT_WIDTH-1:0]    o_head,
    output logic [STAGE_OUT_WIDTH-1:0] o_tail
);

    // Pixel 23 of each row is never consumed, so banks hold 23 pixels only.
    logic [ROW_STORE_WIDTH-1:0] r_bank [2];
    logic [1:0]                 r_full;
    logic                       r_wr_ptr;
    logic                       r_rd_ptr;
    logic [1:0]                 r_count;

    logic w_wr_ok;
    logic w_push;
    logic w_pop;

    // A full bank is never overwritten, even if a caller ignores o_wr_ok.
    assign w_wr_ok = i_wr_en && !r_full[r_wr_ptr];
    assign w_push  = w_wr_ok && i_wr_last;
    assign w_pop   = i_rd_pop && (r_count != 2'd0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the banks are reset on purpose: the outputs must read zero
            // after reset, and a mid-row reset must leave no stale pixels.
            r_bank[0] <= '0;
            r_bank[1] <= '0;
            r_full    <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            // NOTE: state is updated with <= so every read in this block sees
            // the pre-edge value, regardless of statement order.
            if (w_wr_ok) begin
                case (i_wr_beat)
                    2'd0:    r_bank[r_wr_ptr][IN_WIDTH-1:0]              <= i_wr_data;
                    2'd1:    r_bank[r_wr_ptr][2*IN_WIDTH-1:IN_WIDTH]     <= i_wr_data;
                    default: r_bank[r_wr_ptr][ROW_STORE_WIDTH-1:2*IN_WIDTH]
                                 <= i_wr_data[ROW_STORE_WIDTH-2*IN_WIDTH-1:0];
                endcase
            end

            // Push and pop always target different banks: push needs an empty
            // write bank, pop needs a full read bank.
            if (w_push) begin
                r_full[r_wr_ptr] <= 1'b1;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_full[r_rd_ptr] <= 1'b0;
                r_rd_ptr         <= ~r_rd_ptr;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_wr_ok    = (r_count < 2'd2);
    assign o_rd_valid = (r_count != 2'd0);
    assign o_head     = r_bank[r_rd_ptr][OUTPUT_WIDTH-1:0];
    assign o_tail     = r_bank[r_rd_ptr][ROW_STORE_WIDTH-1:OUTPUT_WIDTH];

endmodule

// File: rtl/ref_row_loader.sv
// ---------------------------------------------------------------------------
// ref_row_loader
// Assembles 64-bit reference pixel beats into 23-pixel rows (128-bit head +
// 56-bit tail) for the 2-to-7 shift stage, double-buffered so the next row
// loads while the current one is held.
//   clk_i     : clock, rising edge
//   rst_i     : synchronous active-high reset
//   bus       : ref_row_loader_if.slave (beat input, row output handshakes)
//   err_cnt_o : saturating resync-discard count (ROW_LOADER_ERRCNT_EN only)
// Optional feature macro: ROW_LOADER_ERRCNT_EN
// ---------------------------------------------------------------------------
module ref_row_loader
    import me_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    ref_row_loader_if.slave          bus
`ifdef ROW_LOADER_ERRCNT_EN
    ,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
`endif
);

    wr_state_e  r_state;
    wr_state_e  w_state_nxt;
    logic       w_accept;
    logic       w_resync;
    logic       w_last;
    logic [1:0] w_beat_idx;
    logic       w_buf_ready;
    logic       w_rd_valid;
    logic       w_rd_pop;

    // Ready is held low during reset so no beat slips in alongside it.
    assign bus.in_ready_o = w_buf_ready && !rst_i;
    assign w_accept       = bus.in_valid_i && bus.in_ready_o;
    assign w_rd_pop       = w_rd_valid && bus.out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= W_B0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        w_state_nxt = r_state;
        w_resync    = 1'b0;
        w_last      = 1'b0;
        w_beat_idx  = r_state;

        if (w_accept) begin
            if (bus.in_sof_i && (r_state != W_B0)) begin
                // Start of row mid-row: drop the partial row and restart it
                // with this beat in slot 0 of the same bank.
                w_resync    = 1'b1;
                w_beat_idx  = W_B0;
                w_state_nxt = W_B1;
            end else begin
                case (r_state)
                    W_B0:    w_state_nxt = W_B1;
                    W_B1:    w_state_nxt = W_B2;
                    W_B2: begin
                        w_state_nxt = W_B0;
                        w_last      = 1'b1;
                    end
                    default: w_state_nxt = W_B0;
                endcase
            end
        end
    end

    row_pingpong_buf u_buf (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_wr_en    (w_accept),
        .i_wr_beat  (w_beat_idx),
        .i_wr_data  (bus.in_data_i),
        .i_wr_last  (w_last),
        .i_rd_pop   (w_rd_pop),
        .o_wr_ok    (w_buf_ready),
        .o_rd_valid (w_rd_valid),
        .o_head     (bus.data_out0),
        .o_tail     (bus.data_out1)
    );

    assign bus.out_valid_o = w_rd_valid;

`ifdef ROW_LOADER_ERRCNT_EN
    logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err_cnt <= '0;
        end else if (w_resync && (r_err_cnt != {ERR_CNT_WIDTH{1'b1}})) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign err_cnt_o = r_err_cnt;
`endif

endmodule

// File: tb/tb_ref_row_loader.sv
// ---------------------------------------------------------------------------
// tb_ref_row_loader
// Scoreboard bench for ref_row_loader: stimulus pushes expected rows into a
// queue, an independent monitor compares every presented row against it.
// ---------------------------------------------------------------------------
module tb_ref_row_loader;
    import me_pkg::*;

    typedef logic [ROW_STORE_WIDTH-1:0] row_t;

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    ref_row_loader_if bus ();

`ifdef ROW_LOADER_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    ref_row_loader dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .bus       (bus)
`ifdef ROW_LOADER_ERRCNT_EN
        ,
        .err_cnt_o (err_cnt)
`endif
    );

    row_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pops   = 0;
    int   cyc      = 0;
    bit   rate_en  = 1'b0;
    bit   have_last = 1'b0;
    int   last_pop_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] beat(input int base);
        logic [63:0] b;
        for (int k = 0; k < 8; k++) b[8*k +: 8] = 8'(base + k);
        return b;
    endfunction

    function automatic row_t row_of(input logic [63:0] b0, input logic [63:0] b1,
                                     input logic [63:0] b2);
        return {b2[55:0], b1, b0};
    endfunction

    // Monitor: compare whatever row is presented with the queue head; pop on
    // handshake. Comparing every valid cycle also proves the row holds.
    always @(negedge clk) begin
        if (!rst_i && bus.out_valid_o) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_row: got %h expected no row",
                         {bus.data_out1, bus.data_out0});
            end else begin
                check("row", 192'({bus.data_out1, bus.data_out0}), 192'(exp_q[0]));
                if (bus.out_ready_i) begin
                    void'(exp_q.pop_front());
                    n_pops++;
                    if (rate_en) begin
                        if (have_last) check("row_interval", 192'(cyc - last_pop_cyc), 192'(3));
                        last_pop_cyc = cyc;
                        have_last    = 1'b1;
                    end
                end
            end
        end
        if (!rate_en) have_last = 1'b0;
    end

    task automatic send_beat(input logic [63:0] d, input logic sof);
        int waited = 0;
        bus.in_data_i  = d;
        bus.in_sof_i   = sof;
        bus.in_valid_i = 1'b1;
        @(negedge clk);
        while (!bus.in_ready_o && waited < 60) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.in_ready_o) begin
            n_checks++;
            n_errors++;
            $display("FAIL beat_accept_timeout: in_ready_o=%0b required 1", bus.in_ready_o);
        end
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        bus.in_sof_i   = 1'b0;
    endtask

    task automatic send_row(input logic [63:0] b0, input logic [63:0] b1, input logic [63:0] b2);
        exp_q.push_back(row_of(b0, b1, b2));
        send_beat(b0, 1'b1);
        send_beat(b1, 1'b0);
        send_beat(b2, 1'b0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.out_valid_o) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue", 192'(exp_q.size()), 192'(0));
        check("drain_valid", 192'(bus.out_valid_o), 192'(0));
    endtask

    initial begin
        int n0;
        bus.in_valid_i  = 1'b0;
        bus.in_sof_i    = 1'b0;
        bus.in_data_i   = '0;
        bus.out_ready_i = 1'b1;
        rst_i           = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ready_in_reset", 192'(bus.in_ready_o), 192'(0));
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        check("rst_valid", 192'(bus.out_valid_o), 192'(0));
        check("rst_head", 192'(bus.data_out0), 192'(0));
        check("rst_tail", 192'(bus.data_out1), 192'(0));
        check("rst_ready", 192'(bus.in_ready_o), 192'(1));
`ifdef ROW_LOADER_ERRCNT_EN
        check("rst_errcnt", 192'(err_cnt), 192'(0));
`endif

        // Test 1: single row, hand-computed pixels
        @(posedge clk);
        #1;
        exp_q.push_back({56'h16151413121110, 128'h0F0E0D0C0B0A09080706050403020100});
        send_beat(64'h0706050403020100, 1'b1);
        send_beat(64'h0F0E0D0C0B0A0908, 1'b0);
        send_beat(64'h1716151413121110, 1'b0);
        @(negedge clk);
        check("t1_latency_valid", 192'(bus.out_valid_o), 192'(1));
        @(negedge clk);
        check("t1_one_cycle", 192'(bus.out_valid_o), 192'(0));

        // Test 2: backpressure, both banks fill, seventh beat held off
        @(posedge clk);
        #1 bus.out_ready_i = 1'b0;
        send_row(beat(32), beat(40), beat(48));
        send_row(beat(56), beat(64), beat(72));
        @(negedge clk);
        check("t2_ready_low", 192'(bus.in_ready_o), 192'(0));
        check("t2_valid_held", 192'(bus.out_valid_o), 192'(1));
        fork
            send_row(beat(80), beat(88), beat(96));
            begin
                repeat (8) @(negedge clk);
                check("t2_held_off", 192'(bus.in_ready_o), 192'(0));
                check("t2_no_pop_yet", 192'(n_pops), 192'(1));
                @(posedge clk);
                #1 bus.out_ready_i = 1'b1;
            end
        join
        wait_drain();

        // Test 3: start-of-row on second beat resyncs
        @(posedge clk);
        #1;
        send_beat(beat(100), 1'b1);
        exp_q.push_back(row_of(beat(108), beat(116), beat(124)));
        send_beat(beat(108), 1'b1);
        send_beat(beat(116), 1'b0);
        send_beat(beat(124), 1'b0);
        wait_drain();
`ifdef ROW_LOADER_ERRCNT_EN
        check("t3_errcnt", 192'(err_cnt), 192'(1));
`endif

        // Test 4: streaming, 10 rows at one row per 3 cycles
        @(posedge clk);
        #1;
        rate_en = 1'b1;
        n0 = n_pops;
        for (int r = 0; r < 10; r++)
            send_row(beat(r * 24 + 5), beat(r * 24 + 13), beat(r * 24 + 21));
        wait_drain();
        rate_en = 1'b0;
        check("t4_rows", 192'(n_pops - n0), 192'(10));

        // Test 5: reset after two beats of a row
        @(posedge clk);
        #1;
        send_beat(beat(200), 1'b1);
        send_beat(beat(208), 1'b0);
        rst_i = 1'b1;
        @(negedge clk);
        check("t5_ready_in_reset", 192'(bus.in_ready_o), 192'(0));
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        check("t5_valid", 192'(bus.out_valid_o), 192'(0));
        check("t5_head", 192'(bus.data_out0), 192'(0));
        check("t5_tail", 192'(bus.data_out1), 192'(0));
        check("t5_ready", 192'(bus.in_ready_o), 192'(1));
`ifdef ROW_LOADER_ERRCNT_EN
        check("t5_errcnt", 192'(err_cnt), 192'(0));
`endif
        @(posedge clk);
        #1;
        send_row(beat(150), beat(158), beat(166));
        wait_drain();

`ifdef ROW_LOADER_ERRCNT_EN
        // Test 6: 300 resyncs saturate the error counter
        @(posedge clk);
        #1;
        for (int i = 0; i < 301; i++) send_beat(beat(i), 1'b1);
        @(negedge clk);
        check("t6_errcnt_sat", 192'(err_cnt), 192'(255));
        check("t6_no_row", 192'(bus.out_valid_o), 192'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
